// File: rtl/dac_spi_controller.sv
// Multi-channel SPI DAC controller: double-buffered sample intake, one
// mode-0 SPI frame per channel per sample period, one chip select per channel.
module dac_spi_controller #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_W    = 16,
  parameter int unsigned PAD_HI     = 3,
  parameter int unsigned CH         = 2,
  parameter int unsigned SCK_HALF   = 2,
  parameter int unsigned CS_IDLE    = 2,
  parameter int unsigned SAMPLE_DIV = 2268
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 sck,
  output logic                 mosi,
  output logic [CH-1:0]        cs_n,
  output logic                 busy,
  output logic                 underrun,
  output logic                 overrun
);

  localparam int unsigned CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CH_W     = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned BIT_W    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned HALF_MAX = (SCK_HALF > CS_IDLE) ? SCK_HALF : CS_IDLE;
  localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned LOW_PAD  = FRAME_W - PAD_HI - DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CH*DATA_W-1:0] hold_q, hold_d;
  logic [CH*DATA_W-1:0] shadow_q, shadow_d;
  logic                 full_q, full_d;
  logic [HALF_W-1:0]    half_q, half_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [CH_W-1:0]      ch_q, ch_d;

  logic [CH-1:0]        cs_n_d;
  logic                 sck_d, mosi_d, busy_d, underrun_d, overrun_d;
  logic                 cs_n_unused;

  logic                 tick, accept, start, load_shadow;
  logic                 half_end_sck, half_end_gap;
  logic [DATA_W-1:0]    sel_data;
  logic [FRAME_W-1:0]   sel_frame;

  function automatic logic [FRAME_W-1:0] frame_word(input logic [DATA_W-1:0] s);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[LOW_PAD +: DATA_W] = s;
    return f;
  endfunction

  assign tick         = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign accept       = in_valid & ~full_q;
  assign start        = tick & (state_q == S_IDLE);
  assign load_shadow  = start & full_q;
  assign half_end_sck = (half_q == HALF_W'(SCK_HALF - 1));
  assign half_end_gap = (half_q == HALF_W'(CS_IDLE - 1));
  assign in_ready     = ~full_q;
  assign cs_n_unused  = 1'b0;

  // Free-running sample counter, holding register and shadow register update.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    hold_d   = accept ? in_data : hold_q;
    shadow_d = load_shadow ? hold_q : shadow_q;
    full_d   = full_q;
    if (load_shadow) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
    end
  end

  // Datapath registers: counter, buffers and FSM sequencing counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      half_q   <= '0;
      bit_q    <= '0;
      ch_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      ch_q     <= ch_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: walk bits MSB first, then hold, gap, and next channel.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOW;
          half_d  = '0;
          bit_d   = BIT_W'(FRAME_W - 1);
          ch_d    = '0;
        end
      end
      S_LOW: begin
        if (half_end_sck) begin
          state_d = S_HIGH;
          half_d  = '0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (half_end_sck) begin
          half_d = '0;
          if (bit_q == '0) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_LOW;
            bit_d   = bit_q - 1'b1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (half_end_sck) begin
          state_d = S_GAP;
          half_d  = '0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      S_GAP: begin
        if (half_end_gap) begin
          half_d = '0;
          if (ch_q == CH_W'(CH - 1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LOW;
            ch_d    = ch_q + 1'b1;
            bit_d   = BIT_W'(FRAME_W - 1);
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from next-state values so the pins are registered
  // yet line up with the state they describe in the same cycle.
  always_comb begin
    sel_data = '0;
    cs_n_d   = '1;
    for (int unsigned c = 0; c < CH; c++) begin
      if (ch_d == CH_W'(c)) begin
        sel_data = shadow_d[c*DATA_W +: DATA_W];
        if ((state_d == S_LOW) || (state_d == S_HIGH) || (state_d == S_HOLD)) begin
          cs_n_d[c] = 1'b0;
        end
      end
    end
    sel_frame  = frame_word(sel_data);
    sck_d      = (state_d == S_HIGH);
    mosi_d     = (state_d == S_LOW) ? sel_frame[bit_d] : mosi;
    busy_d     = (state_d != S_IDLE);
    underrun_d = start & ~full_q;
    overrun_d  = tick & (state_q != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_n     <= '1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cs_n     <= cs_n_d | {CH{cs_n_unused}};
      sck      <= sck_d;
      mosi     <= mosi_d;
      busy     <= busy_d;
      underrun <= underrun_d;
      overrun  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_controller.sv
// Scoreboard bench for dac_spi_controller: stimulus pushes expected SPI
// frame words, a negedge monitor decodes the wire and pops/compares them.
module tb_dac_spi_controller;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned CH     = 2;

  logic                 clk;
  logic                 rst;
  logic [CH*DATA_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 sck;
  logic                 mosi;
  logic [CH-1:0]        cs_n;
  logic                 busy;
  logic                 underrun;
  logic                 overrun;

  dac_spi_controller #(
    .DATA_W    (12),
    .FRAME_W   (16),
    .PAD_HI    (3),
    .CH        (2),
    .SCK_HALF  (2),
    .CS_IDLE   (2),
    .SAMPLE_DIV(200)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sck     (sck),
    .mosi    (mosi),
    .cs_n    (cs_n),
    .busy    (busy),
    .underrun(underrun),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned ch;
    logic [15:0] word;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned und_cnt  = 0;
  int unsigned ovr_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] w0, input logic [15:0] w1);
    exp_t e;
    e.ch = 0; e.word = w0; sb_q.push_back(e);
    e.ch = 1; e.word = w1; sb_q.push_back(e);
  endtask

  // Monitor: decode frames, pulse counts and busy length on the wire.
  logic        prev_sck;
  logic        in_frame;
  int unsigned cur_ch, bits, low_cnt, busy_cnt, multi_low;
  logic [15:0] word;

  always @(negedge clk) begin
    if (!rst) begin
      prev_sck  = 1'b0;
      in_frame  = 1'b0;
      bits      = 0;
      low_cnt   = 0;
      busy_cnt  = 0;
      multi_low = 0;
      word      = '0;
    end else begin
      if (underrun) und_cnt++;
      if (overrun) ovr_cnt++;
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        check_eq("busy_len", busy_cnt, 136);
        busy_cnt = 0;
      end
      if ($countones(~cs_n) > 1) multi_low++;
      if (cs_n != '1) begin
        in_frame = 1'b1;
        for (int c = 0; c < CH; c++) if (!cs_n[c]) cur_ch = c;
        low_cnt++;
        if (sck && !prev_sck) begin
          word = {word[14:0], mosi};
          bits++;
        end
      end else if (in_frame) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_frame", sb_q.size(), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("frame_ch", cur_ch, e.ch);
          check_eq("frame_word", word, e.word);
          check_eq("frame_sck_rises", bits, 16);
          check_eq("frame_cs_low", low_cnt, 66);
          check_eq("cs_onehot", multi_low, 0);
        end
        in_frame = 1'b0;
        bits     = 0;
        low_cnt  = 0;
        word     = '0;
      end
      prev_sck = sck;
    end
  end

  task automatic send(input logic [11:0] d0, input logic [11:0] d1, input string tag);
    @(negedge clk);
    in_data  = {d1, d0};
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (!in_ready) begin
      check_eq({tag, "_accept_timeout"}, in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_ready_rise(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (in_ready) break;
    end
    if (!in_ready) check_eq({tag, "_ready_timeout"}, in_ready, 1);
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) check_eq({tag, "_drain_timeout"}, sb_q.size(), 0);
  endtask

  initial begin
    int unsigned base, n;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values.
    #12;
    check_eq("rst_cs_n", cs_n, 2'b11);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic frame.
    push_exp(16'h1578, 16'h0246);
    send(12'hABC, 12'h123, "basic");
    check_eq("basic_full", in_ready, 0);
    wait_ready_rise("basic");
    @(negedge clk);
    check_eq("basic_no_underrun", und_cnt, 0);

    // Repeat: load once, then skip a load.
    push_exp(16'h1000, 16'h0FFE);
    send(12'h800, 12'h7FF, "rep");
    wait_ready_rise("rep");
    push_exp(16'h1000, 16'h0FFE);
    base = und_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (underrun) break;
    end
    check_eq("rep_underrun", underrun, 1);
    @(posedge clk);
    #1;
    check_eq("rep_underrun_width", underrun, 0);
    check_eq("rep_underrun_count", und_cnt - base, 1);
    check_eq("rep_in_ready", in_ready, 1);

    // Backpressure: second value waits for the tick to free the holding register.
    push_exp(16'h0222, 16'h0222);
    send(12'h111, 12'h111, "bp1");
    check_eq("bp_full", in_ready, 0);
    push_exp(16'h0444, 16'h0444);
    send(12'h222, 12'h222, "bp2");
    check_eq("bp_after_tick_cs", cs_n, 2'b10);
    check_eq("bp_after_tick_busy", busy, 1);

    // Same-cycle accept at a tick with the holding register empty.
    wait_ready_rise("sc");
    push_exp(16'h0444, 16'h0444);
    push_exp(16'h0DE0, 16'h001E);
    repeat (200) @(negedge clk);
    in_data  = {12'h00F, 12'h6F0};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("sc_underrun", underrun, 1);
    check_eq("sc_full", in_ready, 0);
    wait_ready_rise("sc2");
    wait_sb_empty("sc");

    // Async reset during bit 5 of ch0 (resend period, not scoreboarded).
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n[0]) break;
    end
    repeat (22) @(posedge clk);
    #2;
    check_eq("pre_rst_mosi", mosi, 1);
    check_eq("pre_rst_sck", sck, 1);
    check_eq("pre_rst_cs_n", cs_n, 2'b10);
    rst = 1'b0;
    #1;
    check_eq("arst_cs_n", cs_n, 2'b11);
    check_eq("arst_sck", sck, 0);
    check_eq("arst_mosi", mosi, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    push_exp(16'h0000, 16'h0000);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (!cs_n[0]) break;
    end
    check_eq("arst_first_tick", n, 200);
    check_eq("arst_underrun", underrun, 1);
    check_eq("arst_in_ready_after", in_ready, 1);
    wait_sb_empty("arst");
    repeat (10) @(posedge clk);

    check_eq("no_overrun", ovr_cnt, 0);
    check_eq("sb_final_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
